button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Upstream stage of the up/down counter system; sits between the raw push-buttons and the counter control FSM.
- Synchronises and debounces the two raw buttons (up, down) and turns each clean press into single-cycle command pulses u and d.
- Optional auto-repeat while a button is held.
- Holds one pending command per direction until the FSM signals it is ready (idle in its verify state), so no press is lost while an operation is in flight.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised level must be stable to be accepted (>=1).
- REPEAT_DELAY, 0: cycles in HELD before the first repeat event; 0 disables auto-repeat.
- REPEAT_PERIOD, 8: cycles between subsequent repeat events (>=1; ignored when REPEAT_DELAY=0).
- CNT_W, 16: width of the internal debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- u_raw  in  1  raw up button, asynchronous, may bounce.
- d_raw  in  1  raw down button, asynchronous, may bounce.
- ready  in  1  from counter FSM: 1 when it can accept a command this cycle.
- u  out  1  one-cycle increment command to FSM.
- d  out  1  one-cycle decrement command to FSM.
- conflict  out  1  one-cycle flag: up and down events cancelled each other.
- dropped  out  1  one-cycle flag: an event arrived while the same direction was already pending.

Behaviour:
- Reset (reset=0, asynchronous):
  - u, d, conflict, dropped = 0.
  - Synchronisers = 0; both channels in IDLE; counters = 0; pending = 0.
  - Reset mid-debounce or mid-hold discards everything; after release, a still-held button must be re-debounced from IDLE.
- Synchroniser: 2-flop per raw input. Only synchronised levels (u_s, d_s) feed logic.
- Per-channel FSM states:
  - IDLE: released and stable. u_s=1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: counter increments while u_s=1. u_s=0 -> IDLE (bounce rejected). Counter reaches DEBOUNCE_CYCLES -> HELD and one press event is raised that cycle.
  - HELD: u_s=0 -> RELEASE_WAIT. If REPEAT_DELAY>0, the repeat counter raises an event after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles while held.
  - RELEASE_WAIT: u_s=1 -> HELD, repeat timing restarts. u_s stays 0 for DEBOUNCE_CYCLES -> IDLE. No event on release.
- Event arbitration, per cycle, after both channels are evaluated:
  - Up and down events in the same cycle: both discarded, conflict=1 next cycle, pending unchanged.
  - Otherwise the event sets that direction's pending bit. If that bit is already set and not consumed this cycle, the event is lost and dropped=1 next cycle.
- Output issue (registered):
  - When ready=1 and exactly one pending bit is set, the matching output is 1 for one cycle and its pending bit clears.
  - Both bits pending with ready=1: issue u first, d on the next ready cycle. Strict up-before-down priority.
  - ready=0: outputs stay 0, pending held indefinitely.
  - u and d are never high in the same cycle. An output is never high two cycles in a row without ready being sampled 1 each cycle.
- Latency, clean press with ready=1: raw rise at edge 0 -> u=1 after edge 2+DEBOUNCE_CYCLES+1. With default DEBOUNCE_CYCLES=4 this is 7 cycles.
- Width rules: counters saturate and never wrap. A button held forever with repeat off yields exactly one event.

Decomposition:
- Shared header (localparam include), used by this block and the bench:
  - channel state encodings IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3.
  - synchroniser depth constant SYNC_STAGES=2.
- Sub-module button_debounce: synchroniser, channel FSM and repeat timer. One instance per button, with output event.
- Arbitration, pending bits and output registers live in button_conditioner.

Test Plan:
- Clean press: hold u_raw=1 for 20 cycles, ready=1 -> u=1 for exactly one cycle, at cycle 7 after the rise; d, conflict and dropped stay 0.
- Bounce rejection: u_raw toggles 1,0,1,0 each cycle for 8 cycles, then settles 0 -> no u pulse. Then hold 1 for 10 cycles -> exactly one u pulse.
- Busy FSM: ready=0, press d (one event), then press d again after release -> one d pulse once ready goes 1 and dropped=1 once; with ready held 1 afterwards no second d.
- Simultaneous: u_raw and d_raw rise on the same edge and are held 10 cycles -> conflict=1 for one cycle; no u or d pulse.
- Auto-repeat: REPEAT_DELAY=10, REPEAT_PERIOD=4, hold u_raw for 30 cycles, ready=1 -> u pulses at cycles 7, 17, 21, 25, 29 after the rise.
- Reset mid-hold: press u, assert reset low at cycle 4, release reset at cycle 6 with u_raw still 1 -> all outputs 0 during reset; u pulses 7 cycles after the reset release edge.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// button_conditioner_pkg
// Shared constants for the push-button front end of the up/down counter:
//   - SYNC_STAGES : depth of the metastability synchroniser on each raw input
//   - chan_state_t: state of one debounce channel
// Imported by button_debounce and button_conditioner.
// ---------------------------------------------------------------------------
package button_conditioner_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_t;

endpackage

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// One button channel: synchroniser, debounce FSM and optional auto-repeat
// timer. Emits a single-cycle registered event on each accepted press and on
// each auto-repeat tick while the button is held.
// Ports:
//   clk       in  system clock, rising edge
//   reset     in  asynchronous active-low reset
//   btn_raw   in  raw, asynchronous, possibly bouncing button level
//   btn_event out one-cycle press / repeat event
// ---------------------------------------------------------------------------
module button_debounce
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_event
);

  // Counters compare against "limit - 1" because the cycle that sees the
  // counter at that value is the cycle in which the limit is reached.
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam bit               REPEAT_EN   = (REPEAT_DELAY > 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  chan_state_t            state;
  logic [CNT_W-1:0]       deb_cnt;
  logic [CNT_W-1:0]       rep_cnt;
  logic                   rep_first;

  // Two-flop synchroniser; only the last stage is allowed to feed logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

  // Channel FSM. A level change is accepted only after it has been seen
  // continuously; the repeat timer restarts every time HELD is (re)entered,
  // and rep_first selects the initial delay versus the steady period.
  // Counters saturate so a stuck button can never wrap them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      btn_event <= 1'b0;
    end else begin
      btn_event <= 1'b0;
      unique case (state)
        IDLE: begin
          if (level) begin
            state   <= PRESS_WAIT;
            deb_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!level) begin
            state <= IDLE;
          end else if (deb_cnt >= DEB_LAST) begin
            state     <= HELD;
            btn_event <= 1'b1;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
          end else if (deb_cnt != CNT_MAX) begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!level) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= '0;
          end else if (REPEAT_EN) begin
            if (rep_cnt >= (rep_first ? DELAY_LAST : PERIOD_LAST)) begin
              btn_event <= 1'b1;
              rep_cnt   <= '0;
              rep_first <= 1'b0;
            end else if (rep_cnt != CNT_MAX) begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end
        RELEASE_WAIT: begin
          if (level) begin
            state     <= HELD;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
          end else if (deb_cnt >= DEB_LAST) begin
            state <= IDLE;
          end else if (deb_cnt != CNT_MAX) begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Front end of the up/down counter: debounces the up and down buttons, holds
// one pending command per direction and issues single-cycle u / d commands
// whenever the counter FSM reports ready.
// Ports:
//   clk      in  system clock, rising edge
//   reset    in  asynchronous active-low reset
//   u_raw    in  raw up button
//   d_raw    in  raw down button
//   ready    in  counter FSM can accept a command this cycle
//   u        out one-cycle increment command
//   d        out one-cycle decrement command
//   conflict out one-cycle flag: up and down events cancelled each other
//   dropped  out one-cycle flag: event lost because that direction was pending
// ---------------------------------------------------------------------------
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic u_raw,
  input  logic d_raw,
  input  logic ready,
  output logic u,
  output logic d,
  output logic conflict,
  output logic dropped
);

  logic ev_u;
  logic ev_d;
  logic pend_u;
  logic pend_d;
  logic arr_u;
  logic arr_d;
  logic avail_u;
  logic avail_d;
  logic issue_u;
  logic issue_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) up_channel (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (u_raw),
    .btn_event(ev_u)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .CNT_W          (CNT_W)
  ) down_channel (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (d_raw),
    .btn_event(ev_d)
  );

  // A simultaneous up/down pair cancels out. A surviving event is visible in
  // the same cycle it arrives (avail_*), so a press with the FSM ready is
  // issued without first sitting a cycle in the pending bit. Up wins when
  // both directions are available.
  always_comb begin
    arr_u   = ev_u & ~ev_d;
    arr_d   = ev_d & ~ev_u;
    avail_u = pend_u | arr_u;
    avail_d = pend_d | arr_d;
    issue_u = ready & avail_u;
    issue_d = ready & ~avail_u & avail_d;
  end

  // Pending bits and registered outputs. When a pending command is issued in
  // the same cycle a new event arrives, the new event takes its place;
  // otherwise an event landing on a set bit is lost and flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_u   <= 1'b0;
      pend_d   <= 1'b0;
      u        <= 1'b0;
      d        <= 1'b0;
      conflict <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      pend_u   <= issue_u ? (pend_u & arr_u) : avail_u;
      pend_d   <= issue_d ? (pend_d & arr_d) : avail_d;
      u        <= issue_u;
      d        <= issue_d;
      conflict <= ev_u & ev_d;
      dropped  <= (arr_u & pend_u & ~issue_u) | (arr_d & pend_d & ~issue_d);
    end
  end

endmodule
